// File: rtl/controlador_barrido_display.sv
// Two-digit multiplexed 7-segment driver: latches a 0-15 value, splits tens/units, scans with gaps.
// Optional leading-zero blanking of the tens slot when BLANQUEO_CERO_IZQ_EN is defined.
module controlador_barrido_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GAP_CYCLES  = 8
) (
    input  logic       reloj,
    input  logic       rst_n,
    input  logic [3:0] dato_i,
    input  logic       dato_valid,
    output logic [6:0] cSeg,
    output logic [3:0] an,
    output logic       En_decena,
    output logic       inicio_trama
);

    localparam int unsigned CntMax   = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
    localparam int unsigned CntRange = (CntMax > 2) ? CntMax : 2;
    localparam int unsigned CntW     = $clog2(CntRange);

    localparam logic [CntW-1:0] RefLast = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {SUni, SGap1, SDec, SGap2} estado_e;

    estado_e         estado_q, estado_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      pend_q, pend_d;
    logic [3:0]      shown_q, shown_d;
    logic            arranque_q;
    logic [6:0]      cseg_q, cseg_d;
    logic [3:0]      an_q, an_d;
    logic            en_dec_q, en_dec_d;
    logic            inicio_q, inicio_d;

    logic            decena;
    logic [3:0]      unidad;
    logic            entrada_uni;

    function automatic logic [6:0] codificar(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q + CntW'(1);
        unique case (estado_q)
            SUni: begin
                if (cnt_q == RefLast) begin
                    estado_d = (GAP_CYCLES == 0) ? SDec : SGap1;
                    cnt_d    = '0;
                end
            end
            SGap1: begin
                if (cnt_q == GapLast) begin
                    estado_d = SDec;
                    cnt_d    = '0;
                end
            end
            SDec: begin
                if (cnt_q == RefLast) begin
                    estado_d = (GAP_CYCLES == 0) ? SUni : SGap2;
                    cnt_d    = '0;
                end
            end
            SGap2: begin
                if (cnt_q == GapLast) begin
                    estado_d = SUni;
                    cnt_d    = '0;
                end
            end
            default: begin
                estado_d = SUni;
                cnt_d    = '0;
            end
        endcase
    end

    // Snapshot only at frame start so a frame never mixes two values; same-edge strobe bypasses.
    always_comb begin
        entrada_uni = (estado_d == SUni) && (estado_q != SUni);
        pend_d      = dato_valid ? dato_i : pend_q;
        shown_d     = shown_q;
        if (entrada_uni) begin
            shown_d = dato_valid ? dato_i : pend_q;
        end
    end

    always_comb begin
        decena = (shown_q >= 4'd10);
        unidad = shown_q - (decena ? 4'd10 : 4'd0);
    end

    // Output registers decode the current state, so every slot appears one edge after it starts.
    always_comb begin
        an_d     = 4'b1111;
        cseg_d   = 7'b1111111;
        en_dec_d = 1'b0;
        inicio_d = (estado_q == SUni) && (cnt_q == '0) && !arranque_q;
        unique case (estado_q)
            SUni: begin
                an_d   = 4'b1110;
                cseg_d = codificar(unidad);
            end
            SDec: begin
                en_dec_d = 1'b1;
                an_d     = 4'b1101;
                cseg_d   = codificar({3'b000, decena});
`ifdef BLANQUEO_CERO_IZQ_EN
                if (!decena) begin
                    an_d   = 4'b1111;
                    cseg_d = 7'b1111111;
                end
`endif
            end
            default: begin
                an_d     = 4'b1111;
                cseg_d   = 7'b1111111;
                en_dec_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= SUni;
            cnt_q      <= '0;
            pend_q     <= 4'd0;
            shown_q    <= 4'd0;
            arranque_q <= 1'b1;
            an_q       <= 4'b1111;
            cseg_q     <= 7'b1111111;
            en_dec_q   <= 1'b0;
            inicio_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            shown_q    <= shown_d;
            arranque_q <= 1'b0;
            an_q       <= an_d;
            cseg_q     <= cseg_d;
            en_dec_q   <= en_dec_d;
            inicio_q   <= inicio_d;
        end
    end

    assign cSeg         = cseg_q;
    assign an           = an_q;
    assign En_decena    = en_dec_q;
    assign inicio_trama = inicio_q;

endmodule

// File: tb/tb_controlador_barrido_display.sv
// Bench for controlador_barrido_display: frame-phase reference model checked every cycle,
// plus literal expectations for reset, digit encodings, bypass and asynchronous reset.
module tb_controlador_barrido_display;

    localparam int R = 4;
    localparam int G = 2;
    localparam int P = 2 * (R + G);

    logic       reloj;
    logic       rst_n;
    logic [3:0] dato_i;
    logic       dato_valid;
    logic [6:0] cSeg;
    logic [3:0] an;
    logic       En_decena;
    logic       inicio_trama;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    controlador_barrido_display #(
        .REFRESH_DIV(R),
        .GAP_CYCLES (G)
    ) dut (
        .reloj       (reloj),
        .rst_n       (rst_n),
        .dato_i      (dato_i),
        .dato_valid  (dato_valid),
        .cSeg        (cSeg),
        .an          (an),
        .En_decena   (En_decena),
        .inicio_trama(inicio_trama)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tabla [10];
        tabla = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tabla[d];
    endfunction

    // Reference: outputs after edge j show frame phase (j-1) mod P using the value latched earlier.
    int         j_m;
    int         p_m;
    int         tens_m;
    logic [3:0] pend_m;
    logic [3:0] shown_m;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_en;
    logic       e_ini;

    always @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            j_m = 0; pend_m = 4'd0; shown_m = 4'd0;
            e_an = 4'hF; e_seg = 7'h7F; e_en = 1'b0; e_ini = 1'b0;
        end else begin
            j_m++;
            p_m   = (j_m - 1) % P;
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_en  = 1'b0;
            e_ini = (p_m == 0) && (j_m > 1);
            if (p_m < R) begin
                e_an  = 4'b1110;
                e_seg = seg_of(int'(shown_m) % 10);
            end else if (p_m >= R + G && p_m < 2 * R + G) begin
                tens_m = int'(shown_m) / 10;
                e_en   = 1'b1;
                e_an   = 4'b1101;
                e_seg  = seg_of(tens_m);
`ifdef BLANQUEO_CERO_IZQ_EN
                if (tens_m == 0) begin
                    e_an  = 4'hF;
                    e_seg = 7'h7F;
                end
`endif
            end
            if (j_m % P == 0) shown_m = dato_valid ? dato_i : pend_m;
            if (dato_valid) pend_m = dato_i;
        end
    end

    always @(negedge reloj) begin
        if (chk_en) begin
            checks++;
            if (an !== e_an || cSeg !== e_seg || En_decena !== e_en || inicio_trama !== e_ini) begin
                errors++;
                $display("FAIL model t=%0t: got an=%b cSeg=%b En=%b ini=%b, want an=%b cSeg=%b En=%b ini=%b",
                         $time, an, cSeg, En_decena, inicio_trama, e_an, e_seg, e_en, e_ini);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic wait_ini();
        int n = 0;
        do begin
            @(posedge reloj);
            #1;
            n++;
        end while (!inicio_trama && n < 60);
        if (!inicio_trama) begin
            checks++;
            errors++;
            $display("FAIL inicio_timeout: got no pulse want pulse within 60 cycles");
        end
    endtask

    task automatic strobe(input logic [3:0] v);
        @(negedge reloj);
        dato_i = v;
        dato_valid = 1'b1;
        @(negedge reloj);
        dato_valid = 1'b0;
    endtask

    task automatic check_tens_blank_or_zero(input string nm);
`ifdef BLANQUEO_CERO_IZQ_EN
        chk({nm, "_an"}, int'(an), 4'b1111);
        chk({nm, "_seg"}, int'(cSeg), 7'b1111111);
`else
        chk({nm, "_an"}, int'(an), 4'b1101);
        chk({nm, "_seg"}, int'(cSeg), 7'b1000000);
`endif
        chk({nm, "_en"}, int'(En_decena), 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        dato_i = 4'd0;
        dato_valid = 1'b0;
        repeat (5) @(negedge reloj);
        chk_en = 1'b1;
        chk("reset_an", int'(an), 4'b1111);
        chk("reset_seg", int'(cSeg), 7'b1111111);
        chk("reset_en", int'(En_decena), 0);
        rst_n = 1'b1;
        @(posedge reloj);
        #1;
        chk("first_an", int'(an), 4'b1110);
        chk("first_seg", int'(cSeg), 7'b1000000);
        chk("first_ini", int'(inicio_trama), 0);

        // Free run: period and slot contents with value 0
        wait_ini();
        n = 0;
        do begin
            @(posedge reloj);
            #1;
            n++;
        end while (!inicio_trama && n < 50);
        chk("frame_period", n, P);
        repeat (R) @(posedge reloj);
        #1;
        chk("gap1_an", int'(an), 4'b1111);
        repeat (G) @(posedge reloj);
        #1;
        check_tens_blank_or_zero("freerun_tens");

        // 7 arrives mid tens slot, shows from next frame
        strobe(4'd7);
        wait_ini();
        chk("seven_units", int'(cSeg), 7'b1111000);
        repeat (R + G) @(posedge reloj);
        #1;
        check_tens_blank_or_zero("seven_tens");

        // 13
        strobe(4'd13);
        wait_ini();
        chk("thirteen_units_seg", int'(cSeg), 7'b0110000);
        chk("thirteen_units_an", int'(an), 4'b1110);
        repeat (R + G) @(posedge reloj);
        #1;
        chk("thirteen_tens_seg", int'(cSeg), 7'b1111001);
        chk("thirteen_tens_an", int'(an), 4'b1101);
        chk("thirteen_tens_en", int'(En_decena), 1);

        // Bypass: pend=5, then 10 strobed on the snapshot edge itself
        strobe(4'd5);
        n = 0;
        while ((j_m + 1) % P != 0 && n < 50) begin
            @(negedge reloj);
            n++;
        end
        dato_i = 4'd10;
        dato_valid = 1'b1;
        @(negedge reloj);
        dato_valid = 1'b0;
        wait_ini();
        chk("bypass_units", int'(cSeg), 7'b1000000);
        repeat (R + G) @(posedge reloj);
        #1;
        chk("bypass_tens", int'(cSeg), 7'b1111001);

        // Random stimulus against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge reloj);
            dato_valid = ($urandom_range(0, 7) == 0);
            dato_i = 4'($urandom_range(0, 15));
        end
        @(negedge reloj);
        dato_valid = 1'b0;

        // Asynchronous reset in the middle of the tens slot showing 15
        strobe(4'd15);
        wait_ini();
        repeat (R + G + 1) @(posedge reloj);
        #1;
        chk("fifteen_tens_seg", int'(cSeg), 7'b1111001);
        chk("fifteen_tens_en", int'(En_decena), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_an", int'(an), 4'b1111);
        chk("async_seg", int'(cSeg), 7'b1111111);
        chk("async_en", int'(En_decena), 0);
        repeat (3) @(negedge reloj);
        rst_n = 1'b1;
        @(posedge reloj);
        #1;
        chk("after_rst_seg", int'(cSeg), 7'b1000000);
        wait_ini();
        chk("pend_cleared_seg", int'(cSeg), 7'b1000000);
        repeat (2 * P) @(posedge reloj);
        @(negedge reloj);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
